// File: rtl/sdr_pkg.sv
// Shared constants and helpers for the ADC sample path.
// Holds the sample/word widths, pack FSM states and sign extension.
package sdr_pkg;

    localparam int SAMPLE_W16 = 16;
    localparam int PACK_W     = 32;
    localparam int DROP_CNT_W = 16;

    localparam logic [0:0] HALF_EMPTY = 1'b0;
    localparam logic [0:0] HALF_FULL  = 1'b1;

    // Replicates bit (width-1) of raw up through bit 15.
    function automatic logic [SAMPLE_W16-1:0] sign_extend(
        input logic [SAMPLE_W16-1:0] raw,
        input int unsigned           width
    );
        int unsigned             sh;
        logic signed [SAMPLE_W16-1:0] t;
        sh = SAMPLE_W16 - width;
        t  = $signed(raw << sh);
        return t >>> sh;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with an exact occupancy count.
// A written word becomes readable one edge after it is stored.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [AW:0]      r_avail;
    logic             r_wr_d;

    logic w_rd;
    logic w_wr;

    assign empty = (r_avail == '0);
    assign full  = (r_level == (AW+1)'(DEPTH));
    assign w_rd  = rd_en & ~empty;
    assign w_wr  = wr_en & (~full | w_rd);
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];
    assign level = r_level;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= din;
    end

    // r_avail trails r_level by the write of the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_avail  <= '0;
            r_wr_d   <= 1'b0;
        end else begin
            r_wr_d <= w_wr;
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_wr}
                               - {{AW{1'b0}}, w_rd};
            r_avail <= r_avail + {{AW{1'b0}}, r_wr_d}
                               - {{AW{1'b0}}, w_rd};
        end
    end

endmodule

// File: rtl/adc_sample_packer.sv
// Packs pairs of sign-extended ADC samples into 32-bit words and
// streams them through a FWFT FIFO with frame markers and status.
module adc_sample_packer
    import sdr_pkg::*;
#(
    parameter int ADC_WIDTH   = 10,
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          clear_stats,
    input  logic [ADC_WIDTH-1:0]          sample_in,
    input  logic                          sample_valid,
    input  logic                          sample_ovf,
    output logic [PACK_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_CNT_W-1:0]         drop_count,
    output logic                          ovf_sticky
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FCW   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [FCW-1:0] LAST_IDX = FCW'(FRAME_WORDS - 1);

    logic [0:0]            r_state;
    logic [SAMPLE_W16-1:0] r_half;
    logic                  r_wr_req;
    logic [PACK_W-1:0]     r_wr_word;
    logic [FCW-1:0]        r_frame_cnt;
    logic [DROP_CNT_W-1:0] r_drop;
    logic                  r_ovf;

    logic [SAMPLE_W16-1:0] w_sext;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd;
    logic                  w_wr_ok;
    logic                  w_drop;
    logic                  w_last;
    logic [PACK_W:0]       w_dout;
    logic [LVL_W-1:0]      w_level;

    assign w_sext  = sign_extend(SAMPLE_W16'(sample_in), ADC_WIDTH);
    assign w_rd    = m_ready & ~w_empty;
    assign w_wr_ok = r_wr_req & (~w_full | w_rd);
    assign w_drop  = r_wr_req & ~w_wr_ok;
    assign w_last  = (r_frame_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= HALF_EMPTY;
            r_half    <= '0;
            r_wr_req  <= 1'b0;
            r_wr_word <= '0;
        end else begin
            r_wr_req <= 1'b0;
            if (!enable) begin
                r_state <= HALF_EMPTY;
            end else if (sample_valid) begin
                if (r_state == HALF_EMPTY) begin
                    r_half  <= w_sext;
                    r_state <= HALF_FULL;
                end else begin
                    r_wr_word <= {w_sext, r_half};
                    r_wr_req  <= 1'b1;
                    r_state   <= HALF_EMPTY;
                end
            end
        end
    end

    // Only words that actually land in the FIFO advance the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (!enable) begin
            r_frame_cnt <= '0;
        end else if (w_wr_ok) begin
            r_frame_cnt <= w_last ? '0 : r_frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (clear_stats) begin
                r_drop <= w_drop ? DROP_CNT_W'(1) : '0;
            end else if (w_drop && r_drop != '1) begin
                r_drop <= r_drop + 1'b1;
            end
            if (sample_valid & enable & sample_ovf) begin
                r_ovf <= 1'b1;
            end else if (clear_stats) begin
                r_ovf <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (PACK_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (w_wr_ok),
        .din   ({w_last, r_wr_word}),
        .full  (w_full),
        .rd_en (w_rd),
        .dout  (w_dout),
        .empty (w_empty),
        .level (w_level)
    );

    assign m_data     = w_dout[PACK_W-1:0];
    assign m_last     = w_dout[PACK_W];
    assign m_valid    = ~w_empty;
    assign fifo_level = w_level;
    assign drop_count = r_drop;
    assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Self-checking bench for adc_sample_packer: vector table, scoreboard
// of expected words, and directed sequences for the corner cases.
module tb_adc_sample_packer;

    localparam int FW = 4;
    localparam int FD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear_stats = 1'b0;
    logic [9:0]  sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ovf = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic [4:0]  fifo_level;
    logic [15:0] drop_count;
    logic        ovf_sticky;

    adc_sample_packer #(
        .ADC_WIDTH   (10),
        .FIFO_DEPTH  (FD),
        .FRAME_WORDS (FW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clear_stats  (clear_stats),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ovf   (sample_ovf),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count),
        .ovf_sticky   (ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  a;
        logic [9:0]  b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [5];
    logic [32:0] sb [$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    int          lasts_seen = 0;
    logic [32:0] mon_w;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none",
                         m_data);
            end else begin
                mon_w = sb.pop_front();
                chk("mon_data", m_data, mon_w[31:0]);
                chk("mon_last", m_last, mon_w[32]);
                if (m_last) lasts_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] s, input logic ovf);
        sample_in    = s;
        sample_ovf   = ovf;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        sample_ovf   = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d);
        sb.push_back({(exp_cnt == FW - 1), d});
        exp_cnt = (exp_cnt + 1) % FW;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || m_valid) && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_queue"}, sb.size(), 0);
        chk({name, "_valid"}, m_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        vecs[0] = '{10'h1FF, 10'h200, 32'hFE00_01FF};
        vecs[1] = '{10'h000, 10'h3FF, 32'hFFFF_0000};
        vecs[2] = '{10'h155, 10'h2AA, 32'hFEAA_0155};
        vecs[3] = '{10'h100, 10'h17F, 32'h017F_0100};
        vecs[4] = '{10'h3FF, 10'h001, 32'h0001_FFFF};

        // reset state
        #3;
        chk("rst_valid", m_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_ovf", ovf_sticky, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        tick();
        rst_n = 1'b1;
        tick();
        enable  = 1'b1;
        m_ready = 1'b1;

        // 1: first word latency
        push_word(32'hFE00_01FF);
        send(10'h1FF, 1'b0);
        send(10'h200, 1'b0);
        chk("t1_lat0", m_valid, 0);
        tick();
        chk("t1_lat1", m_valid, 0);
        tick();
        chk("t1_lat2", m_valid, 1);
        chk("t1_data", m_data, 32'hFE00_01FF);
        drain("t1");

        for (int i = 0; i < 5; i++) begin
            push_word(vecs[i].exp);
            send(vecs[i].a, 1'b0);
            send(vecs[i].b, 1'b0);
        end
        drain("tab");

        // 2: enable drop discards partial word
        push_word(32'h0002_0001);
        send(10'h001, 1'b0);
        send(10'h002, 1'b0);
        send(10'h003, 1'b0);
        enable = 1'b0;
        tick();
        enable  = 1'b1;
        exp_cnt = 0;
        push_word(32'h0005_0004);
        send(10'h004, 1'b0);
        send(10'h005, 1'b0);
        drain("t2");

        // 3: frame markers
        enable = 1'b0;
        tick();
        enable  = 1'b1;
        exp_cnt = 0;
        l0 = lasts_seen;
        for (int w = 0; w < 12; w++) begin
            push_word({16'(2 * w + 11), 16'(2 * w + 10)});
            send(10'(2 * w + 10), 1'b0);
            send(10'(2 * w + 11), 1'b0);
        end
        drain("t3");
        chk("t3_lasts", lasts_seen - l0, 3);

        // 4: overflow of the FIFO
        m_ready = 1'b0;
        enable  = 1'b0;
        tick();
        enable  = 1'b1;
        exp_cnt = 0;
        for (int w = 0; w < 20; w++) begin
            if (w < FD) push_word({16'hFF00 + 16'(w), 16'(w + 1)});
            send(10'(w + 1), 1'b0);
            send(10'h300 + 10'(w), 1'b0);
        end
        repeat (3) tick();
        chk("t4_level", fifo_level, 16);
        chk("t4_drop", drop_count, 4);
        chk("t4_valid", m_valid, 1);
        chk("t4_hold", m_data, 32'hFF00_0001);
        m_ready = 1'b1;
        for (int i = 0; i < FD; i++) begin
            chk("t4_nogap", m_valid, 1);
            tick();
        end
        chk("t4_empty", m_valid, 0);
        chk("t4_level0", fifo_level, 0);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("t4_dropclr", drop_count, 0);

        // 5: sticky overflow
        chk("t5_ovf0", ovf_sticky, 0);
        push_word(32'h0020_0010);
        send(10'h010, 1'b1);
        chk("t5_set", ovf_sticky, 1);
        send(10'h020, 1'b0);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("t5_clr", ovf_sticky, 0);
        push_word(32'h0040_0030);
        clear_stats = 1'b1;
        send(10'h030, 1'b1);
        clear_stats = 1'b0;
        chk("t5_setwins", ovf_sticky, 1);
        send(10'h040, 1'b0);
        drain("t5");

        // 6: async reset mid-pair with words queued
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(10'(i + 5), (i == 0));
        repeat (3) tick();
        chk("t6_level3", fifo_level, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", m_valid, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_drop", drop_count, 0);
        chk("t6_ovf", ovf_sticky, 0);
        rst_n   = 1'b1;
        exp_cnt = 0;
        tick();
        m_ready = 1'b1;
        push_word(32'h0077_0055);
        send(10'h055, 1'b0);
        send(10'h077, 1'b0);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
